// File: rtl/cap_arb.sv
// cap_arb: packet-granular arbiter that shares one capture-FIFO write port
// between the RX tap (source 0) and the TX tap (source 1). Each packet is
// prefixed with a header word {2'b10, src, 0..., seq}. The write port is locked
// to one source until that source's last word. Data words past MAX_WORDS are
// consumed and dropped.
module cap_arb #(
  parameter int MAX_WORDS = 384,
  parameter int SEQ_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  src_valid,
  input  logic [31:0] src_data0,
  input  logic [31:0] src_data1,
  input  logic [1:0]  src_last,
  output logic [1:0]  src_ready,
  input  logic        almost_full,
  output logic        fifo_wr,
  output logic [31:0] fifo_in,
  output logic        active_src,
  output logic        busy,
  output logic        pkt_done,
  output logic        trunc
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t            state;
  logic              rr;
  logic [SEQ_W-1:0]  seq;
  logic [CNT_W-1:0]  count;

  logic [1:0]        ready_s;
  logic              grant_s;
  logic              hs_s;
  logic              cur_last_s;
  logic [31:0]       cur_data_s;

  // Header word: marker bits, source ID, zero padding, then sequence number
  function automatic logic [31:0] make_hdr(input logic src, input logic [SEQ_W-1:0] s);
    logic [31:0] h;
    h = 32'd0;
    h[31:30] = 2'b10;
    h[29] = src;
    h[SEQ_W-1:0] = s;
    return h;
  endfunction

  // Per-source ready: only the locked source sees ready; DROP ignores backpressure
  always_comb begin
    ready_s = 2'b00;
    case (state)
      DATA:    ready_s[active_src] = !almost_full;
      DROP:    ready_s[active_src] = 1'b1;
      default: ready_s = 2'b00;
    endcase
  end

  // Grant choice, selected-source word mux and handshake detection
  always_comb begin
    if (src_valid == 2'b11) begin
      grant_s = rr;
    end else begin
      grant_s = src_valid[1];
    end
    if (active_src) begin
      cur_data_s = src_data1;
    end else begin
      cur_data_s = src_data0;
    end
    cur_last_s = src_last[active_src];
    hs_s = src_valid[active_src] & ready_s[active_src];
  end

  assign src_ready = ready_s;
  assign busy      = (state != IDLE);

  // Arbitration FSM with registered FIFO write, done and truncation pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      seq        <= '0;
      count      <= '0;
      active_src <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_in    <= 32'd0;
      pkt_done   <= 1'b0;
      trunc      <= 1'b0;
    end else begin
      fifo_wr  <= 1'b0;
      pkt_done <= 1'b0;
      trunc    <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (src_valid != 2'b00)) begin
            active_src <= grant_s;
            rr         <= ~grant_s;
            state      <= HDR;
          end
        end
        HDR: begin
          if (!almost_full) begin
            fifo_wr <= 1'b1;
            fifo_in <= make_hdr(active_src, seq);
            seq     <= seq + SEQ_W'(1);
            count   <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (hs_s) begin
            fifo_wr <= 1'b1;
            fifo_in <= cur_data_s;
            count   <= count + CNT_W'(1);
            if (cur_last_s) begin
              pkt_done <= 1'b1;
              state    <= IDLE;
            end else if (count == CNT_LAST) begin
              // The MAX_WORDS-th word is written; the rest of the packet is drained
              trunc <= 1'b1;
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (hs_s && cur_last_s) begin
            pkt_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cap_arb.sv
// Testbench for cap_arb (MAX_WORDS=4, SEQ_W=2): table of single-source packets
// plus hand-written round-robin, backpressure, enable and mid-packet reset cases.
module tb_cap_arb;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  src_valid;
  logic [31:0] src_data0;
  logic [31:0] src_data1;
  logic [1:0]  src_last;
  logic [1:0]  src_ready;
  logic        almost_full;
  logic        fifo_wr;
  logic [31:0] fifo_in;
  logic        active_src;
  logic        busy;
  logic        pkt_done;
  logic        trunc;

  cap_arb #(.MAX_WORDS(4), .SEQ_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_valid(src_valid), .src_data0(src_data0), .src_data1(src_data1),
    .src_last(src_last), .src_ready(src_ready), .almost_full(almost_full),
    .fifo_wr(fifo_wr), .fifo_in(fifo_in), .active_src(active_src),
    .busy(busy), .pkt_done(pkt_done), .trunc(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int pd_cnt, tr_cnt, tr_pos, ready_err;
  logic [1:0] pre_ready;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] cap[$];
  logic [31:0] expq[$];

  typedef struct {
    logic        src;
    int          len;
    logic [31:0] base;
    logic [31:0] hdr;
    int          exp_trunc;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic [32:0] w;
    src_valid = 2'b00; src_last = 2'b00; src_data0 = 32'd0; src_data1 = 32'd0;
    if (q0.size() > 0) begin
      w = q0[0];
      src_valid[0] = 1'b1; src_last[0] = w[32]; src_data0 = w[31:0];
    end
    if (q1.size() > 0) begin
      w = q1[0];
      src_valid[1] = 1'b1; src_last[1] = w[32]; src_data1 = w[31:0];
    end
  endtask

  // One clock: note handshakes before the edge, then pop sources and monitor outputs
  task automatic step();
    logic [1:0] hs;
    #1;
    hs = src_valid & src_ready;
    pre_ready = src_ready;
    if (busy && src_ready[active_src ^ 1'b1]) ready_err++;
    if (!busy && (src_ready != 2'b00)) ready_err++;
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    if (fifo_wr) cap.push_back(fifo_in);
    if (pkt_done) pd_cnt++;
    if (trunc) begin
      tr_cnt++;
      tr_pos = cap.size();
    end
    drive();
  endtask

  task automatic load(input logic s, input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [32:0] w;
      w = {(i == len - 1), base + 32'(i)};
      if (s) q1.push_back(w);
      else q0.push_back(w);
    end
    drive();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((q0.size() > 0) || (q1.size() > 0) || busy) && (n < budget));
    check({name, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  task automatic clear_mon();
    cap.delete(); pd_cnt = 0; tr_cnt = 0; tr_pos = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete();
    drive();
    step(); step();
    reset = 1'b0;
    enable = 1'b1;
    clear_mon();
  endtask

  task automatic check_cap(input string name);
    check({name, "_count"}, 64'(cap.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < cap.size()) check($sformatf("%s_w%0d", name, i), 64'(cap[i]), 64'(expq[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    reset = 1'b1; enable = 1'b0; almost_full = 1'b0; ready_err = 0;
    q0.delete(); q1.delete();
    drive();
    vecs[0] = '{1'b0, 3, 32'hA0, 32'h8000_0000, 0};
    vecs[1] = '{1'b1, 7, 32'hB0, 32'hA000_0001, 1};
    vecs[2] = '{1'b1, 4, 32'hC0, 32'hA000_0002, 0};
    vecs[3] = '{1'b0, 1, 32'hD0, 32'h8000_0003, 0};
    vecs[4] = '{1'b0, 2, 32'hE0, 32'h8000_0000, 0};

    do_reset();
    check("reset_outputs",
          {25'd0, src_ready, fifo_wr, fifo_in, active_src, busy, pkt_done, trunc}, 64'd0);

    // Table: single-source packets, truncation, exact boundary, sequence wrap
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      load(vecs[i].src, vecs[i].base, vecs[i].len);
      wait_idle($sformatf("vec%0d", i), 100);
      nd = (vecs[i].len > 4) ? 4 : vecs[i].len;
      expq.delete();
      expq.push_back(vecs[i].hdr);
      for (int k = 0; k < nd; k++) expq.push_back(vecs[i].base + 32'(k));
      check_cap($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pkt_done", i), 64'(pd_cnt), 64'd1);
      check($sformatf("vec%0d_trunc", i), 64'(tr_cnt), 64'(vecs[i].exp_trunc));
      if (vecs[i].exp_trunc != 0) check($sformatf("vec%0d_trunc_pos", i), 64'(tr_pos), 64'd5);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // Backpressure: 5-cycle almost_full stall after the first data word
    do_reset();
    load(1'b0, 32'h30, 4);
    for (int n = 0; n < 20 && cap.size() < 2; n++) step();
    almost_full = 1'b1;
    begin
      int stall_err;
      stall_err = 0;
      for (int n = 0; n < 5; n++) begin
        step();
        if (pre_ready != 2'b00) stall_err++;
        if (cap.size() != 2) stall_err++;
      end
      check("bp_stall", 64'(stall_err), 64'd0);
    end
    almost_full = 1'b0;
    wait_idle("bp", 100);
    expq = '{32'h8000_0000, 32'h30, 32'h31, 32'h32, 32'h33};
    check_cap("bp");
    check("bp_trunc", 64'(tr_cnt), 64'd0);

    // Round robin: both sources continuously valid with 2-word packets
    do_reset();
    load(1'b0, 32'h10, 2); load(1'b0, 32'h12, 2);
    load(1'b1, 32'h20, 2); load(1'b1, 32'h22, 2);
    wait_idle("rr", 200);
    expq = '{32'h8000_0000, 32'h10, 32'h11, 32'hA000_0001, 32'h20, 32'h21,
             32'h8000_0002, 32'h12, 32'h13, 32'hA000_0003, 32'h22, 32'h23};
    check_cap("rr");
    check("rr_pkt_done", 64'(pd_cnt), 64'd4);

    // Enable dropped during packet 3 data: it completes, no further grants
    do_reset();
    load(1'b0, 32'h40, 1); load(1'b0, 32'h41, 1); load(1'b0, 32'h42, 2); load(1'b0, 32'h44, 1);
    for (int n = 0; n < 50 && cap.size() < 5; n++) step();
    enable = 1'b0;
    for (int n = 0; n < 15; n++) step();
    expq = '{32'h8000_0000, 32'h40, 32'h8000_0001, 32'h41, 32'h8000_0002, 32'h42, 32'h43};
    check_cap("en_off");
    check("en_off_busy", 64'(busy), 64'd0);
    check("en_off_pending", 64'(q0.size()), 64'd1);
    enable = 1'b1;
    wait_idle("en_on", 50);
    expq.push_back(32'h8000_0003); expq.push_back(32'h44);
    check_cap("en_on");

    // Reset during data word 2, after a grant left the pointer at source 1
    clear_mon();
    load(1'b0, 32'h50, 4);
    for (int n = 0; n < 50 && cap.size() < 2; n++) step();
    reset = 1'b1;
    step();
    check("midrst_outputs",
          {25'd0, src_ready, fifo_wr, fifo_in, active_src, busy, pkt_done, trunc}, 64'd0);
    reset = 1'b0;
    q0.delete(); q1.delete();
    clear_mon();
    load(1'b0, 32'h60, 2); load(1'b1, 32'h70, 2);
    wait_idle("midrst", 100);
    expq = '{32'h8000_0000, 32'h60, 32'h61, 32'hA000_0001, 32'h70, 32'h71};
    check_cap("midrst");

    check("nongranted_ready", 64'(ready_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
